// File: rtl/stopwatch_if.sv
// stopwatch_if: front-panel pulses, digit chain feedback and
// controller outputs for stopwatch_ctrl.
interface stopwatch_if #(
  parameter int N_DIGITS = 4
);
  logic                start;
  logic                stop;
  logic                clear;
  logic [N_DIGITS-1:0] co;
  logic [N_DIGITS-1:0] digit_en;
  logic                cnt_clr;
  logic                tick;
  logic                running;
  logic                full;
  logic                ovf;

  modport master (
    output start, stop, clear, co,
    input  digit_en, cnt_clr, tick,
    input  running, full, ovf
  );

  modport slave (
    input  start, stop, clear, co,
    output digit_en, cnt_clr, tick,
    output running, full, ovf
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear FSM and tick prescaler
// sequencing a cascaded chain of decade digit counters.
module stopwatch_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int TICK_DIV = 100000,
  parameter int WRAP     = 0
) (
  input logic       clk,
  input logic       rst_n,
  stopwatch_if.slave bus
);

  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DMAX = DW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    FULL  = 2'd3
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          tick_q;
  logic          tick_nxt;
  logic          clr_q;
  logic          ovf_q;
  logic          ovf_nxt;

  logic                is_run;
  logic                top;
  logic                hold;
  logic                carry;
  logic [N_DIGITS-1:0] en;

  assign is_run = (state == RUN);
  assign top    = tick_q & is_run & (&bus.co);
  assign hold   = (WRAP == 0) & top;

  // Ripple the count enable up the chain through each digit's carry.
  always_comb begin
    en    = '0;
    carry = tick_q & is_run & ~hold & ~bus.clear;
    for (int k = 0; k < N_DIGITS; k++) begin
      en[k] = carry;
      carry = carry & bus.co[k];
    end
  end

  // Next state, prescaler advance and rollover detection.
  always_comb begin
    nxt      = state;
    div_nxt  = div_cnt;
    tick_nxt = 1'b0;
    ovf_nxt  = 1'b0;
    if (bus.clear) begin
      nxt     = IDLE;
      div_nxt = '0;
    end else begin
      if (is_run) begin
        tick_nxt = (div_cnt == DMAX);
        div_nxt  = (div_cnt == DMAX) ? '0
                                     : div_cnt + 1'b1;
      end
      ovf_nxt = (WRAP != 0) & top;
      unique case (state)
        IDLE:
          if (bus.start && !bus.stop)
            nxt = RUN;
        RUN:
          if (hold)
            nxt = FULL;
          else if (bus.stop)
            nxt = PAUSE;
        PAUSE:
          if (bus.start && !bus.stop)
            nxt = RUN;
        FULL:
          nxt = FULL;
        default:
          nxt = IDLE;
      endcase
    end
  end

  // State, prescaler and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= nxt;
      div_cnt <= div_nxt;
      tick_q  <= tick_nxt;
      clr_q   <= bus.clear;
      ovf_q   <= ovf_nxt;
    end
  end

  assign bus.digit_en = en;
  assign bus.cnt_clr  = clr_q;
  assign bus.tick     = tick_q;
  assign bus.running  = is_run;
  assign bus.full     = (state == FULL);
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: drives a WRAP=0 and a WRAP=1 controller
// with shared stimulus, scoreboarded against a decimal model.
module tb_stopwatch_ctrl;

  localparam int N    = 2;
  localparam int TD   = 4;
  localparam int MAXV = 99;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_FULL  = 3;

  typedef struct packed {
    logic [N-1:0] en;
    logic         clr;
    logic         tick;
    logic         run;
    logic         full;
    logic         ovf;
    logic [15:0]  cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  stopwatch_if #(.N_DIGITS(N)) ifc0 ();
  stopwatch_if #(.N_DIGITS(N)) ifc1 ();

  stopwatch_ctrl #(
    .N_DIGITS(N), .TICK_DIV(TD), .WRAP(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(ifc0.slave)
  );

  stopwatch_ctrl #(
    .N_DIGITS(N), .TICK_DIV(TD), .WRAP(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(ifc1.slave)
  );

  logic [3:0] dg0 [N];
  logic [3:0] dg1 [N];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < N; k++) begin
      if (!rst_n) dg0[k] <= 4'd0;
      else if (ifc0.cnt_clr) dg0[k] <= 4'd0;
      else if (ifc0.digit_en[k])
        dg0[k] <= (dg0[k] == 4'd9) ? 4'd0 : dg0[k] + 4'd1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < N; k++) begin
      if (!rst_n) dg1[k] <= 4'd0;
      else if (ifc1.cnt_clr) dg1[k] <= 4'd0;
      else if (ifc1.digit_en[k])
        dg1[k] <= (dg1[k] == 4'd9) ? 4'd0 : dg1[k] + 4'd1;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_co
    assign ifc0.co[g] = (dg0[g] == 4'd9);
    assign ifc1.co[g] = (dg1[g] == 4'd9);
  end

  int m_mode  [2];
  int m_phase [2];
  int m_count [2];
  bit m_tick  [2];
  bit m_clr   [2];
  bit m_ovf   [2];

  obs_t q0 [$];
  obs_t q1 [$];
  bit   done = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_no = 0;

  function automatic logic [N-1:0] en_mask(input int v);
    logic [N-1:0] m;
    int t;
    m = '0;
    t = 0;
    while (t < N && (v % 10) == 9) begin
      t++;
      v = v / 10;
    end
    for (int i = 0; i < N; i++)
      if (i <= t) m[i] = 1'b1;
    return m;
  endfunction

  function automatic int decimal(input logic [3:0] d [N]);
    int v;
    v = 0;
    for (int k = N - 1; k >= 0; k--)
      v = v * 10 + int'(d[k]);
    return v;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_mode[w]  = M_IDLE;
      m_phase[w] = 0;
      m_count[w] = 0;
      m_tick[w]  = 1'b0;
      m_clr[w]   = 1'b0;
      m_ovf[w]   = 1'b0;
    end
  endtask

  task automatic model_step(input int w, input bit s,
                            input bit p, input bit c,
                            output obs_t e);
    bit run;
    bit top;
    bit ev;
    int nmode;
    run = (m_mode[w] == M_RUN);
    top = m_tick[w] && run && (m_count[w] == MAXV);
    ev  = m_tick[w] && run && !c && !(w == 0 && top);
    e.en   = ev ? en_mask(m_count[w]) : '0;
    e.clr  = m_clr[w];
    e.tick = m_tick[w];
    e.run  = run;
    e.full = (m_mode[w] == M_FULL);
    e.ovf  = m_ovf[w];
    e.cnt  = 16'(m_count[w]);
    nmode = m_mode[w];
    if (c) nmode = M_IDLE;
    else if (m_mode[w] == M_IDLE || m_mode[w] == M_PAUSE) begin
      if (s && !p) nmode = M_RUN;
    end else if (run) begin
      if (w == 0 && top) nmode = M_FULL;
      else if (p) nmode = M_PAUSE;
    end
    if (m_clr[w]) m_count[w] = 0;
    else if (ev) m_count[w] = (m_count[w] + 1) % (MAXV + 1);
    m_ovf[w]  = (w == 1) && top && !c;
    m_tick[w] = !c && run && (m_phase[w] == TD - 1);
    if (c) m_phase[w] = 0;
    else if (run) m_phase[w] = (m_phase[w] + 1) % TD;
    m_clr[w]  = c;
    m_mode[w] = nmode;
  endtask

  task automatic push_step(input bit s, input bit p, input bit c);
    obs_t e;
    ifc0.start = s; ifc0.stop = p; ifc0.clear = c;
    ifc1.start = s; ifc1.stop = p; ifc1.clear = c;
    model_step(0, s, p, c, e);
    q0.push_back(e);
    model_step(1, s, p, c, e);
    q1.push_back(e);
  endtask

  task automatic cyc(input bit s, input bit p, input bit c);
    @(posedge clk);
    #2;
    push_step(s, p, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted off the clock edge, held across one edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    push_step(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    push_step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input int w, input obs_t got,
                       input obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL dut%0d cyc%0d: got en=%b clr=%b tick=%b run=%b full=%b ovf=%b cnt=%0d, required en=%b clr=%b tick=%b run=%b full=%b ovf=%b cnt=%0d",
               w, cyc_no, got.en, got.clr, got.tick, got.run,
               got.full, got.ovf, got.cnt, exp.en, exp.clr,
               exp.tick, exp.run, exp.full, exp.ovf, exp.cnt);
    end
  endtask

  // Monitor: pop one expectation per DUT each mid-cycle sample.
  initial begin
    obs_t g;
    obs_t e;
    int guard;
    guard = 0;
    while (!(done && q0.size() == 0 && q1.size() == 0)) begin
      @(negedge clk);
      cyc_no++;
      guard++;
      if (guard > 50000) begin
        n_bad++;
        $display("FAIL timeout: got %0d cycles, required < 50000",
                 guard);
        break;
      end
      if (q0.size() > 0) begin
        e = q0.pop_front();
        g.en = ifc0.digit_en; g.clr = ifc0.cnt_clr;
        g.tick = ifc0.tick; g.run = ifc0.running;
        g.full = ifc0.full; g.ovf = ifc0.ovf;
        g.cnt = 16'(decimal(dg0));
        check(0, g, e);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        g.en = ifc1.digit_en; g.clr = ifc1.cnt_clr;
        g.tick = ifc1.tick; g.run = ifc1.running;
        g.full = ifc1.full; g.ovf = ifc1.ovf;
        g.cnt = 16'(decimal(dg1));
        check(1, g, e);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  // Stimulus: directed scenarios, then random pulses.
  initial begin
    bit s;
    bit p;
    bit c;
    ifc0.start = 1'b0; ifc0.stop = 1'b0; ifc0.clear = 1'b0;
    ifc1.start = 1'b0; ifc1.stop = 1'b0; ifc1.clear = 1'b0;
    async_reset();
    idle(3);
    cyc(1'b1, 1'b0, 1'b0);
    idle(420);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    idle(3);
    cyc(1'b0, 1'b0, 1'b1);
    idle(3);
    cyc(1'b1, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, 1'b1, 1'b0);
    idle(20);
    cyc(1'b1, 1'b0, 1'b0);
    idle(12);
    cyc(1'b1, 1'b1, 1'b1);
    idle(3);
    cyc(1'b1, 1'b0, 1'b0);
    idle(4);
    cyc(1'b0, 1'b1, 1'b0);
    idle(3);
    cyc(1'b1, 1'b0, 1'b0);
    idle(9);
    async_reset();
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1499) == 0) begin
        async_reset();
      end else begin
        s = ($urandom_range(0, 999) < 60);
        p = ($urandom_range(0, 99) < 3);
        c = ($urandom_range(0, 999) < 4);
        cyc(s, p, c);
      end
    end
    idle(2);
    done = 1'b1;
  end

endmodule
